// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory image loader.
// State encoding, ack bytes and the default packet sync marker.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RESP
  } state_t;

  localparam logic [7:0] ACK_OK            = 8'h4B;
  localparam logic [7:0] ACK_ERR           = 8'h45;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler with a running mod-256 checksum.
// The completed word is presented combinationally with the strobe for byte 3.
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word,
  output logic [7:0]  sum
);

  // Only the first three bytes need storing; byte 3 comes straight from the input.
  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;
  logic [7:0]  sum_reg;

  assign word_done = byte_en && (cnt_reg == 2'd3);
  assign word      = {byte_in, shift_reg};
  assign sum       = sum_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= 24'd0;
      cnt_reg   <= 2'd0;
      sum_reg   <= 8'd0;
    end else if (byte_en) begin
      shift_reg <= {byte_in, shift_reg[23:8]};
      cnt_reg   <= cnt_reg + 2'd1;
      sum_reg   <= sum_reg + byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image from the UART RX stream into instruction memory,
// holding the CPU in reset until a load completes with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_00C8,
  parameter int unsigned MAX_WORDS = 7950,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

  state_t      state_reg;
  logic [7:0]  len_lo_reg;
  logic [15:0] length_reg;
  logic [15:0] word_idx_reg;

  logic        accept;
  logic        asm_clear;
  logic        asm_byte_en;
  logic        asm_word_done;
  logic [31:0] asm_word;
  logic [7:0]  asm_sum;
  logic [15:0] length_next;

  assign rx_ready    = (state_reg != IDLE) && (state_reg != RESP);
  assign busy        = (state_reg != IDLE);
  assign accept      = rx_valid && rx_ready;
  assign asm_clear   = (state_reg == IDLE) && start;
  assign asm_byte_en = accept && (state_reg == DATA);
  assign length_next = {rx_data, len_lo_reg};

  imem_loader_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (asm_byte_en),
    .byte_in   (rx_data),
    .word_done (asm_word_done),
    .word      (asm_word),
    .sum       (asm_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      len_lo_reg    <= 8'd0;
      length_reg    <= 16'd0;
      word_idx_reg  <= 16'd0;
      mem_we        <= 1'b0;
      mem_waddr     <= BASE_ADDR;
      mem_wdata     <= 32'd0;
      tx_data       <= 8'd0;
      tx_valid      <= 1'b0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= SYNC;
            word_idx_reg  <= 16'd0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= 16'd0;
            cpu_hold      <= 1'b1;
          end
        end
        SYNC: begin
          if (accept && (rx_data == SYNC_BYTE)) state_reg <= LEN0;
        end
        LEN0: begin
          if (accept) begin
            len_lo_reg <= rx_data;
            state_reg  <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            length_reg <= length_next;
            if (32'(length_next) > MAX_WORDS) begin
              tx_data   <= ACK_ERR;
              tx_valid  <= 1'b1;
              state_reg <= RESP;
            end else if (length_next == 16'd0) begin
              state_reg <= CSUM;
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (asm_word_done) begin
            mem_we       <= 1'b1;
            mem_waddr    <= BASE_ADDR + {14'd0, word_idx_reg, 2'b00};
            mem_wdata    <= asm_word;
            word_idx_reg <= word_idx_reg + 16'd1;
            if (words_written != MAX_W16) words_written <= words_written + 16'd1;
            if (word_idx_reg + 16'd1 == length_reg) state_reg <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            tx_data   <= (rx_data == asm_sum) ? ACK_OK : ACK_ERR;
            tx_valid  <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          // tx_valid/tx_data stay frozen until the UART takes the byte.
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            state_reg <= IDLE;
            if (tx_data == ACK_OK) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: packet framing, writes, ack, backpressure, reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int checks = 0;
  int failures = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          we_double = 0;
  logic        prev_we = 1'b0;

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // Write capture: log every write and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
      if (prev_we === 1'b1) we_double++;
      $display("write addr=%h data=%h", mem_waddr, mem_wdata);
    end
    prev_we = mem_we;
  end

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    we_double = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL start_busy busy=%b cpu_hold=%b required 1/1", busy, cpu_hold);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_nominal(input logic [7:0] csum);
    logic [7:0] pkt [12];
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h73, 8'h00, 8'h10, 8'h00, 8'h00};
    pkt[11] = csum;
    for (int i = 0; i < 12; i++) send_byte(pkt[i]);
  endtask

  // Waits for the ack byte and returns after the TX handshake edge.
  task automatic get_ack(output logic [7:0] d);
    int n;
    n = 0;
    d = 8'h00;
    while (tx_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (tx_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout tx_valid=%b required 1", tx_valid);
    end else begin
      d = tx_data;
      n = 0;
      while (tx_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
    end
    $display("ack byte=%h done=%b error=%b cpu_hold=%b", d, done, error, cpu_hold);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, tx_valid, cpu_hold, busy, done, error} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required 0000000",
               {rx_ready, mem_we, tx_valid, cpu_hold, busy, done, error});
    end
    checks++;
    if (mem_waddr !== 32'h0000_00C8) begin
      failures++;
      $display("FAIL reset_waddr got=%h required 000000c8", mem_waddr);
    end
    checks++;
    if (mem_wdata !== 32'd0 || tx_data !== 8'd0 || words_written !== 16'd0) begin
      failures++;
      $display("FAIL reset_data wdata=%h tx_data=%h ww=%0d required 0/0/0",
               mem_wdata, tx_data, words_written);
    end
  endtask

  task automatic check_nominal_writes(input string tag);
    checks++;
    if (wa_q.size() != 2) begin
      failures++;
      $display("FAIL %s_wr_count got=%0d required 2", tag, wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 32'hC8 || wd_q[0] !== 32'h0000_0013) begin
        failures++;
        $display("FAIL %s_wr0 addr=%h data=%h required 000000c8/00000013", tag, wa_q[0], wd_q[0]);
      end
      checks++;
      if (wa_q[1] !== 32'hCC || wd_q[1] !== 32'h0010_0073) begin
        failures++;
        $display("FAIL %s_wr1 addr=%h data=%h required 000000cc/00100073", tag, wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (we_double != 0) begin
      failures++;
      $display("FAIL %s_we_pulse long_pulses=%0d required 0", tag, we_double);
    end
  endtask

  task automatic test_nominal();
    logic [7:0] ack;
    clear_log();
    do_start();
    send_nominal(8'h96);
    get_ack(ack);
    checks++;
    if (ack !== 8'h4B) begin
      failures++;
      $display("FAIL nominal_ack got=%h required 4b", ack);
    end
    check_nominal_writes("nominal");
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nominal_status done=%b error=%b hold=%b busy=%b required 1/0/0/0",
               done, error, cpu_hold, busy);
    end
    checks++;
    if (words_written !== 16'd2) begin
      failures++;
      $display("FAIL nominal_words got=%0d required 2", words_written);
    end
  endtask

  task automatic test_sync_hunt();
    logic [7:0] pkt [11];
    logic [7:0] ack;
    pkt = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    clear_log();
    do_start();
    // A second start while busy must not disturb the load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 11; i++) send_byte(pkt[i]);
    get_ack(ack);
    checks++;
    if (ack !== 8'h4B) begin
      failures++;
      $display("FAIL sync_ack got=%h required 4b", ack);
    end
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'hC8 || wd_q[0] !== 32'h0403_0201) begin
      failures++;
      $display("FAIL sync_write count=%0d addr=%h data=%h required 1/000000c8/04030201",
               wa_q.size(), wa_q[0], wd_q[0]);
    end
    checks++;
    if (words_written !== 16'd1 || done !== 1'b1) begin
      failures++;
      $display("FAIL sync_status ww=%0d done=%b required 1/1", words_written, done);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] ack;
    clear_log();
    do_start();
    send_nominal(8'h97);
    get_ack(ack);
    checks++;
    if (ack !== 8'h45) begin
      failures++;
      $display("FAIL badcsum_ack got=%h required 45", ack);
    end
    check_nominal_writes("badcsum");
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || words_written !== 16'd2) begin
      failures++;
      $display("FAIL badcsum_status error=%b done=%b hold=%b ww=%0d required 1/0/1/2",
               error, done, cpu_hold, words_written);
    end
  endtask

  task automatic test_oversize();
    logic [7:0] ack;
    clear_log();
    do_start();
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_byte(8'h27);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin
      failures++;
      $display("FAIL oversize_immediate tx_valid=%b tx_data=%h required 1/45", tx_valid, tx_data);
    end
    get_ack(ack);
    checks++;
    if (ack !== 8'h45 || error !== 1'b1) begin
      failures++;
      $display("FAIL oversize_ack ack=%h error=%b required 45/1", ack, error);
    end
    checks++;
    if (wa_q.size() != 0 || words_written !== 16'd0) begin
      failures++;
      $display("FAIL oversize_nowrite writes=%0d ww=%0d required 0/0", wa_q.size(), words_written);
    end
  endtask

  task automatic test_backpressure_zero();
    int bad;
    bad = 0;
    clear_log();
    tx_ready = 1'b0;
    do_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h4B || cpu_hold !== 1'b1 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold unstable_cycles=%0d required 0", bad);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL bp_complete tx_valid=%b done=%b error=%b hold=%b required 0/1/0/0",
               tx_valid, done, error, cpu_hold);
    end
    checks++;
    if (wa_q.size() != 0 || words_written !== 16'd0) begin
      failures++;
      $display("FAIL bp_nowrite writes=%0d ww=%0d required 0/0", wa_q.size(), words_written);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] pkt [6];
    logic [7:0] ack;
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    clear_log();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(pkt[i]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rx_ready, mem_we, tx_valid, cpu_hold, busy, done, error} !== 7'b0 ||
        words_written !== 16'd0) begin
      failures++;
      $display("FAIL midreset_flags got=%b ww=%0d required 0000000/0",
               {rx_ready, mem_we, tx_valid, cpu_hold, busy, done, error}, words_written);
    end
    checks++;
    if (mem_waddr !== 32'hC8 || mem_wdata !== 32'd0 || wa_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_mem waddr=%h wdata=%h writes=%0d required 000000c8/0/0",
               mem_waddr, mem_wdata, wa_q.size());
    end
    reset = 1'b0;
    clear_log();
    do_start();
    send_nominal(8'h96);
    get_ack(ack);
    checks++;
    if (ack !== 8'h4B || done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL midreset_reload ack=%h done=%b hold=%b required 4b/1/0", ack, done, cpu_hold);
    end
    check_nominal_writes("midreset");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sync_hunt();
    test_bad_csum();
    test_oversize();
    test_backpressure_zero();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
